// File: rtl/bus_xfer_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_xfer_sched_pkg
// Brief    : Shared op/state encodings and bus-select helpers for bus_xfer_sched.
// Revision : 1.0
// ============================================================================
package bus_xfer_sched_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_MOVE = 2'b01,
        OP_SWAP = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    localparam logic [2:0] BUS_DATA       = 3'b000;
    localparam logic       BUS_REG_PREFIX = 1'b1;

    function automatic logic [2:0] bus_reg(input logic [1:0] idx);
        return {BUS_REG_PREFIX, idx};
    endfunction

    function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_xfer_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first request at or after ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic             valid
);

    int w_idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        w_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!valid && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_xfer_sched.sv
`default_nettype none
// ============================================================================
// Module   : bus_xfer_sched
// Brief    : Round-robin sequencer for LOAD/MOVE/SWAP transfers on a shared bus.
// Revision : 1.0
// ============================================================================
module bus_xfer_sched
    import bus_xfer_sched_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int TEMP = 3
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [NREQ-1:0]   Req,
    input  logic [2*NREQ-1:0] ReqOp,
    input  logic [2*NREQ-1:0] ReqRs,
    input  logic [2*NREQ-1:0] ReqRd,
    output logic [NREQ-1:0]   Gnt,
    output logic [2:0]        BusSel,
    output logic [3:0]        Rin,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    localparam int         PTR_W  = (NREQ > 2) ? 2 : 1;
    localparam logic [1:0] c_temp = 2'(TEMP);

    state_e           r_state;
    state_e           w_next;
    logic [PTR_W-1:0] r_ptr;
    op_e              r_op;
    logic [1:0]       r_rs;
    logic [1:0]       r_rd;

    logic [NREQ-1:0]  w_win;
    logic             w_valid;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [1:0]       w_op_raw;
    logic [1:0]       w_rs;
    logic [1:0]       w_rd;
    op_e              w_op;
    logic             w_illegal;
    logic             w_accept;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (Req),
        .ptr   (r_ptr),
        .gnt   (w_win),
        .valid (w_valid)
    );

    // Mux out the winner's fields and the pointer value just past it.
    always_comb begin
        w_op_raw  = 2'b00;
        w_rs      = 2'b00;
        w_rd      = 2'b00;
        w_ptr_nxt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win[i]) begin
                w_op_raw  = ReqOp[2*i +: 2];
                w_rs      = ReqRs[2*i +: 2];
                w_rd      = ReqRd[2*i +: 2];
                w_ptr_nxt = (i + 1 == NREQ) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    assign w_op = op_e'(w_op_raw);

    always_comb begin
        w_illegal = 1'b0;
        case (w_op)
            OP_LOAD: w_illegal = (w_rd == c_temp);
            OP_MOVE,
            OP_SWAP: w_illegal = (w_rs == c_temp) || (w_rd == c_temp);
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_accept = (r_state == ST_IDLE) && w_valid;

    // Grant is Mealy from IDLE; gated by Resetn so it drops with the reset.
    assign Gnt = ((r_state == ST_IDLE) && Resetn) ? w_win : '0;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_op    <= OP_LOAD;
            r_rs    <= 2'b00;
            r_rd    <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_ptr <= w_ptr_nxt;
                r_op  <= w_op;
                r_rs  <= w_rs;
                r_rd  <= w_rd;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        BusSel = BUS_DATA;
        Rin    = 4'b0000;
        Busy   = 1'b1;
        Done   = 1'b0;
        Err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                Busy = 1'b0;
                if (w_valid) begin
                    w_next = w_illegal ? ST_ERR : ST_S1;
                end
            end
            ST_S1: begin
                case (r_op)
                    OP_LOAD: begin
                        Rin    = reg_onehot(r_rd);
                        Done   = 1'b1;
                        w_next = ST_IDLE;
                    end
                    OP_MOVE: begin
                        BusSel = bus_reg(r_rs);
                        Rin    = reg_onehot(r_rd);
                        Done   = 1'b1;
                        w_next = ST_IDLE;
                    end
                    OP_SWAP: begin
                        BusSel = bus_reg(r_rs);
                        Rin    = reg_onehot(c_temp);
                        w_next = ST_S2;
                    end
                    default: begin
                        Done   = 1'b1;
                        w_next = ST_IDLE;
                    end
                endcase
            end
            ST_S2: begin
                BusSel = bus_reg(r_rd);
                Rin    = reg_onehot(r_rs);
                w_next = ST_S3;
            end
            ST_S3: begin
                BusSel = bus_reg(c_temp);
                Rin    = reg_onehot(r_rd);
                Done   = 1'b1;
                w_next = ST_IDLE;
            end
            ST_ERR: begin
                Err    = 1'b1;
                Done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_xfer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_xfer_sched
// Brief    : Randomized self-checking bench with register-bank and RR model.
// Revision : 1.0
// ============================================================================
module tb_bus_xfer_sched;

    localparam int NREQ = 3;
    localparam int TEMP = 3;

    logic              Clock  = 1'b0;
    logic              Resetn = 1'b0;
    logic [NREQ-1:0]   Req    = '0;
    logic [2*NREQ-1:0] ReqOp  = '0;
    logic [2*NREQ-1:0] ReqRs  = '0;
    logic [2*NREQ-1:0] ReqRd  = '0;
    logic [NREQ-1:0]   Gnt;
    logic [2:0]        BusSel;
    logic [3:0]        Rin;
    logic              Busy;
    logic              Done;
    logic              Err;
    logic [7:0]        Data   = 8'h00;

    logic [7:0] bank [4];
    logic [7:0] refr [4];
    int n_cmp  = 0;
    int n_fail = 0;
    int mptr   = 0;

    always #5 Clock = ~Clock;

    bus_xfer_sched #(.NREQ(NREQ), .TEMP(TEMP)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Req    (Req),
        .ReqOp  (ReqOp),
        .ReqRs  (ReqRs),
        .ReqRd  (ReqRd),
        .Gnt    (Gnt),
        .BusSel (BusSel),
        .Rin    (Rin),
        .Busy   (Busy),
        .Done   (Done),
        .Err    (Err)
    );

    // External register bank driven by the scheduler's controls.
    always @(posedge Clock) begin
        for (int i = 0; i < 4; i++) begin
            if (Rin[i]) bank[i] <= (BusSel == 3'b000) ? Data : bank[BusSel[1:0]];
        end
    end

    function automatic bit is_illegal(input logic [1:0] op, input logic [1:0] rs, input logic [1:0] rd);
        if (op == 2'b11) return 1'b1;
        if (op == 2'b00) return (rd == 2'(TEMP));
        return (rs == 2'(TEMP)) || (rd == 2'(TEMP));
    endfunction

    // Effect of one completed transfer on the register contents.
    function automatic void apply_ref(input logic [1:0] op, input logic [1:0] rs, input logic [1:0] rd,
                                      input logic [7:0] dat);
        logic [7:0] t;
        if (is_illegal(op, rs, rd)) return;
        case (op)
            2'b00: refr[rd] = dat;
            2'b01: refr[rd] = refr[rs];
            default: begin
                t = refr[rs]; refr[rs] = refr[rd]; refr[rd] = t;
            end
        endcase
    endfunction

    task automatic do_xfer(input string name, input logic [NREQ-1:0] req,
                           input logic [2*NREQ-1:0] ops, input logic [2*NREQ-1:0] rss,
                           input logic [2*NREQ-1:0] rds, input logic [7:0] dat);
        int w, nst, guard;
        logic [1:0] op, rs, rd;
        logic [NREQ-1:0] eg;
        logic [15:0] ev [3];
        logic [15:0] ob;
        @(negedge Clock);
        guard = 0;
        while (Busy && guard < 8) begin
            @(negedge Clock);
            guard++;
        end
        n_cmp++;
        if (Busy) begin
            n_fail++;
            $display("FAIL %s idle-wait: Busy=%b required 0", name, Busy);
            return;
        end
        Req = req; ReqOp = ops; ReqRs = rss; ReqRd = rds; Data = dat;
        #1;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && req[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
        end
        eg = '0; eg[w] = 1'b1;
        n_cmp++;
        if (Gnt !== eg) begin
            n_fail++;
            $display("FAIL %s grant: got %b required %b", name, Gnt, eg);
        end
        @(posedge Clock); #1;
        Req = '0;
        mptr = (w + 1) % NREQ;
        op = ops[2*w +: 2]; rs = rss[2*w +: 2]; rd = rds[2*w +: 2];
        // Vector layout: {Gnt, BusSel, Rin, Busy, Done, Err}
        if (is_illegal(op, rs, rd)) begin
            nst = 1; ev[0] = {3'b000, 3'b000, 4'b0000, 3'b111};
        end else if (op == 2'b00) begin
            nst = 1; ev[0] = {3'b000, 3'b000, 4'b0001 << rd, 3'b110};
        end else if (op == 2'b01) begin
            nst = 1; ev[0] = {3'b000, 1'b1, rs, 4'b0001 << rd, 3'b110};
        end else begin
            nst = 3;
            ev[0] = {3'b000, 1'b1, rs, 4'b0001 << TEMP, 3'b100};
            ev[1] = {3'b000, 1'b1, rd, 4'b0001 << rs, 3'b100};
            ev[2] = {3'b000, 1'b1, 2'(TEMP), 4'b0001 << rd, 3'b110};
        end
        for (int s = 0; s < nst; s++) begin
            @(negedge Clock);
            ob = {3'b000, Gnt, BusSel, Rin, Busy, Done, Err};
            n_cmp++;
            if (ob !== ev[s]) begin
                n_fail++;
                $display("FAIL %s step%0d {Gnt,BusSel,Rin,Busy,Done,Err}: got %b required %b",
                         name, s, ob[12:0], ev[s][12:0]);
            end
        end
        apply_ref(op, rs, rd, dat);
        @(negedge Clock);
        n_cmp++;
        if ({Busy, Done, Err} !== 3'b000 || {bank[0], bank[1], bank[2]} !== {refr[0], refr[1], refr[2]}) begin
            n_fail++;
            $display("FAIL %s after: Busy/Done/Err=%b R0..R2=%h %h %h required 000 %h %h %h", name,
                     {Busy, Done, Err}, bank[0], bank[1], bank[2], refr[0], refr[1], refr[2]);
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0; Req = '1;
        @(negedge Clock); #1;
        n_cmp++;
        if ({Gnt, BusSel, Rin, Busy, Done, Err} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got %b required 0", {Gnt, BusSel, Rin, Busy, Done, Err});
        end
        Req = '0;
        @(negedge Clock);
        Resetn = 1'b1; mptr = 0;
    endtask

    task automatic test_load();
        do_xfer("load_r1", 3'b001, 6'b000000, 6'b000000, 6'b000001, 8'h5A);
        do_xfer("load_r0", 3'b010, 6'b000000, 6'b000000, 6'b000000, 8'h11);
        do_xfer("load_r2", 3'b100, 6'b000000, 6'b000000, 6'b100000, 8'h22);
    endtask

    task automatic test_swap();
        do_xfer("swap_r0_r2", 3'b001, 6'b000010, 6'b000000, 6'b000010, 8'hEE);
        n_cmp++;
        if (bank[0] !== 8'h22 || bank[2] !== 8'h11) begin
            n_fail++;
            $display("FAIL swap result: R0=%h R2=%h required 22 11", bank[0], bank[2]);
        end
        do_xfer("swap_same", 3'b010, 6'b001000, 6'b000100, 6'b000100, 8'hEE);
    endtask

    task automatic test_rr_order();
        bit mbusy;
        logic [NREQ-1:0] eg;
        logic [1:0] srcs [3] = '{2'd0, 2'd1, 2'd2};
        logic [1:0] dsts [3] = '{2'd1, 2'd2, 2'd0};
        @(negedge Clock); Resetn = 1'b0;
        @(negedge Clock); Resetn = 1'b1; mptr = 0;
        Req = 3'b111; ReqOp = 6'b010101; ReqRs = 6'b100100; ReqRd = 6'b001001;
        mbusy = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge Clock);
            #1;
            eg = '0;
            if (!mbusy) eg[mptr] = 1'b1;
            n_cmp++;
            if ({Gnt, Done} !== {eg, mbusy}) begin
                n_fail++;
                $display("FAIL rr cycle%0d {Gnt,Done}: got %b required %b", c, {Gnt, Done}, {eg, mbusy});
            end
            if (!mbusy) begin
                apply_ref(2'b01, srcs[mptr], dsts[mptr], 8'h00);
                mptr = (mptr + 1) % NREQ;
            end
            mbusy = !mbusy;
        end
        Req = '0;
        @(negedge Clock);
        n_cmp++;
        if ({bank[0], bank[1], bank[2]} !== {refr[0], refr[1], refr[2]}) begin
            n_fail++;
            $display("FAIL rr regs: got %h %h %h required %h %h %h",
                     bank[0], bank[1], bank[2], refr[0], refr[1], refr[2]);
        end
    endtask

    task automatic test_err();
        do_xfer("err_move_temp", 3'b010, 6'b000100, 6'b001100, 6'b000000, 8'h00);
        do_xfer("err_load_temp", 3'b001, 6'b000000, 6'b000000, 6'b000011, 8'h77);
        do_xfer("err_rsvd", 3'b100, 6'b110000, 6'b000000, 6'b010000, 8'h00);
        do_xfer("after_err", 3'b001, 6'b000000, 6'b000000, 6'b000010, 8'hC3);
    endtask

    task automatic test_busy_wait();
        @(negedge Clock);
        Req = 3'b001; ReqOp = 6'b000010; ReqRs = 6'b000000; ReqRd = 6'b000010;
        #1;
        n_cmp++;
        if (Gnt !== 3'b001) begin
            n_fail++;
            $display("FAIL busy_wait grant0: got %b required 001", Gnt);
        end
        @(posedge Clock); #1;
        mptr = 1;
        Req = 3'b100; ReqOp = 6'b010010; ReqRs = 6'b010000; ReqRd = 6'b000010;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clock);
            n_cmp++;
            if ({Gnt, Busy} !== 4'b0001) begin
                n_fail++;
                $display("FAIL busy_wait hold%0d {Gnt,Busy}: got %b required 0001", c, {Gnt, Busy});
            end
        end
        apply_ref(2'b10, 2'd0, 2'd2, 8'h00);
        @(negedge Clock);
        n_cmp++;
        if ({Gnt, Busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL busy_wait grant2 {Gnt,Busy}: got %b required 1000", {Gnt, Busy});
        end
        @(posedge Clock); #1;
        Req = '0; mptr = 0;
        apply_ref(2'b01, 2'd1, 2'd0, 8'h00);
        @(negedge Clock);
        n_cmp++;
        if ({BusSel, Rin, Done} !== 8'b101_0001_1) begin
            n_fail++;
            $display("FAIL busy_wait move {BusSel,Rin,Done}: got %b required 10100011", {BusSel, Rin, Done});
        end
        @(negedge Clock);
        n_cmp++;
        if ({bank[0], bank[1], bank[2]} !== {refr[0], refr[1], refr[2]}) begin
            n_fail++;
            $display("FAIL busy_wait regs: got %h %h %h required %h %h %h",
                     bank[0], bank[1], bank[2], refr[0], refr[1], refr[2]);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge Clock);
        Req = 3'b001; ReqOp = 6'b000010; ReqRs = 6'b000000; ReqRd = 6'b000001;
        @(posedge Clock); #1;
        Req = '0;
        @(negedge Clock);
        @(negedge Clock);
        n_cmp++;
        if ({Busy, Rin} !== 5'b1_0001) begin
            n_fail++;
            $display("FAIL reset_mid s2 {Busy,Rin}: got %b required 10001", {Busy, Rin});
        end
        Resetn = 1'b0;
        Req = 3'b010; ReqOp = 6'b000100; ReqRs = 6'b000000; ReqRd = 6'b001000;
        #1;
        n_cmp++;
        if ({Gnt, Rin, Busy, Done} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_mid abort {Gnt,Rin,Busy,Done}: got %b required 0", {Gnt, Rin, Busy, Done});
        end
        @(negedge Clock);
        Resetn = 1'b1; mptr = 0;
        #1;
        n_cmp++;
        if (Gnt !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_mid regrant: got %b required 010", Gnt);
        end
        @(posedge Clock); #1;
        Req = '0; mptr = 2;
        apply_ref(2'b01, 2'd0, 2'd2, 8'h00);
        @(negedge Clock);
        @(negedge Clock);
        n_cmp++;
        if ({bank[0], bank[1], bank[2]} !== {refr[0], refr[1], refr[2]}) begin
            n_fail++;
            $display("FAIL reset_mid regs: got %h %h %h required %h %h %h",
                     bank[0], bank[1], bank[2], refr[0], refr[1], refr[2]);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] rq;
        logic [2*NREQ-1:0] ro, rs, rd;
        for (int n = 0; n < 40; n++) begin
            rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            ro = '0; rs = '0; rd = '0;
            for (int i = 0; i < NREQ; i++) begin
                ro[2*i +: 2] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                rs[2*i +: 2] = 2'($urandom_range(0, 3));
                rd[2*i +: 2] = 2'($urandom_range(0, 3));
            end
            do_xfer("random", rq, ro, rs, rd, 8'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) refr[i] = 8'hxx;
        test_reset();
        test_load();
        test_swap();
        test_rr_order();
        test_err();
        test_busy_wait();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_xfer_sched.md
Name: bus_xfer_sched

Overview:
- Round-robin scheduler that shares one n-bit bus and four bus registers R0..R3 among NREQ requesters.
- Each granted request runs one of three transfer operations:
  - LOAD: external Data -> Rd
  - MOVE: Rs -> Rd
  - SWAP: Rs <-> Rd, through temp register R[TEMP]
- Drives the bus-mux select and register load enables.
- Sits beside the register bank/bus mux as its sole sequencer. Registers and mux stay outside this block.

Parameters:
- NREQ, 3, number of requesters; supported range 2..4.
- TEMP, 3, index of the register reserved as swap temporary.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Req  in  NREQ  per-requester request level.
- ReqOp  in  2*NREQ  op per requester, slice [2i+1:2i]: 00 LOAD, 01 MOVE, 10 SWAP, 11 reserved.
- ReqRs  in  2*NREQ  source register index per requester.
- ReqRd  in  2*NREQ  destination register index per requester.
- Gnt  out  NREQ  one-hot grant, asserted for the single cycle in which the request is accepted.
- BusSel  out  3  bus mux select: 000 = Data; 1xx = R[xx]; other codes unused.
- Rin  out  4  load enable for R0..R3.
- Busy  out  1  high in every non-IDLE state.
- Done  out  1  high in the final cycle of an operation, including the error cycle.
- Err  out  1  high in the ERR cycle.

Behaviour:
- Reset: Resetn=0 forces asynchronously:
  - state IDLE, RR pointer 0;
  - BusSel=000, Rin=0, Busy=0, Done=0, Err=0, Gnt=0.
  - Reset mid-operation aborts immediately with Rin dropped. No rollback: a partially executed SWAP leaves registers partially updated.
- FSM states: IDLE, S1, S2, S3, ERR.
- IDLE, Gnt (Mealy):
  - When any Req is high, the winner is the first requester at or after the RR pointer (ascending index, wrapping).
  - Gnt[winner] is combinational in that cycle.
  - On the next rising edge: latch winner's op/Rs/Rd; pointer <= (winner+1) mod NREQ; state <= S1, or ERR if illegal.
  - Requesters hold Req and fields stable until they see Gnt. Req dropped before grant is lost without error.
- Illegal request:
  - op = 11, or
  - MOVE/SWAP with Rs==TEMP or Rd==TEMP, or
  - LOAD with Rd==TEMP.
- ERR: Err=1, Done=1, Rin=0, BusSel=000; then IDLE.
- S1 (Moore outputs):
  - LOAD: BusSel=000, Rin[Rd]=1, Done=1 -> IDLE.
  - MOVE: BusSel=1Rs, Rin[Rd]=1, Done=1 -> IDLE.
  - SWAP: BusSel=1Rs, Rin[TEMP]=1 -> S2.
- S2 (SWAP only): BusSel=1Rd, Rin[Rs]=1 -> S3.
- S3 (SWAP only): BusSel=1TEMP, Rin[Rd]=1, Done=1 -> IDLE.
- Rin is one-hot or zero in every state. Never more than one register loads per cycle.
- SWAP with Rs==Rd is legal and runs all three steps; register contents end unchanged.
- Latency from the grant cycle: Done follows after 1 cycle for LOAD/MOVE and after 3 cycles for SWAP.
- No new grant while Busy. Back-to-back operations are possible: Done cycle -> IDLE grant on the next cycle.
- Requests arriving while Busy wait. The pointer does not move except on a grant.

Decomposition:
- Shared package holds:
  - op encodings OP_LOAD/OP_MOVE/OP_SWAP/OP_RSVD;
  - state encodings;
  - BUS_DATA = 3'b000 and the BusSel register-prefix constant.
- One sub-module: rr_arbiter (Req, pointer -> one-hot winner, valid). Pure combinational; the pointer register stays in bus_xfer_sched.

Test Plan:
- Reset then Req=001, op LOAD, Rd=1 -> Gnt=001 same cycle; next cycle BusSel=000, Rin=0010, Done=1; then Busy=0.
- Req0 SWAP Rs=0 Rd=2 -> three cycles with (BusSel,Rin) = (100,1000), (110,0001), (111,0100); Done only in the third. With register models preloaded R0=0x11 and R2=0x22, the result is R0=0x22, R2=0x11.
- Req=111 held continuously, all MOVE -> grants in order 001, 010, 100, 001. After reset the pointer is 0, so requester 0 is served first.
- Req1 MOVE Rs=3 (TEMP) -> ERR cycle with Err=1, Done=1, Rin=0, and no register load; the next request is then served normally.
- Req2 asserted during a SWAP for Req0 -> Gnt[2] only in the IDLE cycle after Done, never while Busy=1.
- Resetn pulsed low in S2 -> Rin=0 and Busy=0 immediately. After release, the pointer is 0 and a pending Req=010 is granted.
